// File: rtl/adc_frame_rx.sv
// Serial ADC frame receiver: synchronizes drdyn/dclk/dout, shifts DATA_W bits MSB first
// and presents each completed sample with valid/ack handshake, overflow and abort flags.
module adc_frame_rx #(
    parameter int unsigned DATA_W      = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              drdyn,
    input  logic              dclk,
    input  logic              dout,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ack,
    output logic              ovf,
    output logic              err,
    output logic              sel
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_HI = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] drdyn_sync;
    logic [SYNC_STAGES-1:0] dclk_sync;
    logic [SYNC_STAGES-1:0] dout_sync;
    logic [SYNC_STAGES-1:0] live_sync;

    logic drdyn_s;
    logic dclk_s;
    logic dout_s;
    logic live_s;

    logic dclk_d;
    logic drdyn_d;
    logic armed;
    logic rise_q;
    logic fall_q;
    logic drdyn_q;
    logic bit_q;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                valid_nxt;
    logic                ovf_nxt;
    logic                sel_nxt;
    logic                err_nxt;
    logic                complete;

    // Identical synchronizer chains keep drdyn, dclk and dout cycle-aligned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drdyn_sync <= '1;
            dclk_sync  <= '0;
            dout_sync  <= '0;
            live_sync  <= '0;
        end else begin
            drdyn_sync <= {drdyn_sync[SYNC_STAGES-2:0], drdyn};
            dclk_sync  <= {dclk_sync[SYNC_STAGES-2:0], dclk};
            dout_sync  <= {dout_sync[SYNC_STAGES-2:0], dout};
            live_sync  <= {live_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign drdyn_s = drdyn_sync[SYNC_STAGES-1];
    assign dclk_s  = dclk_sync[SYNC_STAGES-1];
    assign dout_s  = dout_sync[SYNC_STAGES-1];
    assign live_s  = live_sync[SYNC_STAGES-1];

    // A drdyn fall only counts once a genuine high has been seen after reset,
    // so the reset value of the chain cannot fake the start of a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dclk_d  <= 1'b0;
            drdyn_d <= 1'b1;
            armed   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            drdyn_q <= 1'b1;
            bit_q   <= 1'b0;
        end else begin
            dclk_d  <= dclk_s;
            drdyn_d <= drdyn_s;
            armed   <= armed | (live_s & drdyn_s);
            rise_q  <= dclk_s & ~dclk_d;
            fall_q  <= armed & drdyn_d & ~drdyn_s;
            drdyn_q <= drdyn_s;
            bit_q   <= dout_s;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        data_nxt  = data;
        valid_nxt = valid;
        ovf_nxt   = ovf;
        sel_nxt   = sel;
        err_nxt   = 1'b0;
        complete  = 1'b0;

        case (state)
            IDLE: begin
                if (fall_q) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    shreg_nxt = '0;
                end
            end
            SHIFT: begin
                if (rise_q && (cnt == CNT_W'(DATA_W - 1))) begin
                    complete  = 1'b1;
                    shreg_nxt = {shreg[DATA_W-2:0], bit_q};
                    cnt_nxt   = cnt + CNT_W'(1);
                    data_nxt  = {shreg[DATA_W-2:0], bit_q};
                    sel_nxt   = ~sel;
                    state_nxt = WAIT_HI;
                end else if (drdyn_q) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (rise_q) begin
                    shreg_nxt = {shreg[DATA_W-2:0], bit_q};
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (drdyn_q) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Acknowledge first, then a completing frame re-arms valid on top of it.
        if (valid && ack) begin
            valid_nxt = 1'b0;
            ovf_nxt   = 1'b0;
        end
        if (complete) begin
            valid_nxt = 1'b1;
            if (valid && !ack) begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            data  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            sel   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            data  <= data_nxt;
            valid <= valid_nxt;
            ovf   <= ovf_nxt;
            sel   <= sel_nxt;
            err   <= err_nxt;
        end
    end

endmodule

// File: doc/adc_frame_rx.md
ADC_FRAME_RX -- requirements
Module: adc_frame_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24, bits per ADC frame (range 8..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for drdyn, dclk and dout (min 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, system clock, all state on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port drdyn, input, 1, ADC data-ready, active low, frames a transfer; asynchronous to clk.
REQ-007 SHALL have port dclk, input, 1, ADC serial data clock; asynchronous to clk.
REQ-008 SHALL have port dout, input, 1, ADC serial data, MSB first, stable around dclk rising edge.
REQ-009 SHALL have port data, output, DATA_W, last completed sample.
REQ-010 SHALL have port valid, output, 1, data holds an unacknowledged sample.
REQ-011 SHALL have port ack, input, 1, consumer acknowledge of data.
REQ-012 SHALL have port ovf, output, 1, sticky: completed sample overwrote an unacknowledged one.
REQ-013 SHALL have port err, output, 1, one-cycle pulse: frame aborted short.
REQ-014 SHALL have port sel, output, 1, channel indicator; toggles per completed frame.

Function
REQ-015 SHALL pass drdyn, dclk, dout through identical SYNC_STAGES flop chains so all three stay cycle-aligned.
REQ-016 SHALL detect dclk rise as synchronized dclk = 1 and its one-cycle-delayed copy = 0; dclk high and low phases are each at least 3 clk periods.
REQ-017 SHALL implement FSM IDLE, SHIFT, WAIT_HI.
REQ-018 IDLE: synchronized drdyn falling edge -> SHIFT, bit counter cleared; dclk rises in IDLE are ignored.
REQ-019 SHIFT: each dclk rise shifts synchronized dout into the LSB of the shift register and increments the bit counter.
REQ-020 SHIFT: on the DATA_W-th rise, same cycle: data <= completed word, valid <= 1, sel toggles, -> WAIT_HI.
REQ-021 SHIFT: synchronized drdyn high before DATA_W rises -> err = 1 for one cycle, data/valid/sel unchanged, -> IDLE.
REQ-022 Simultaneous DATA_W-th rise and drdyn rise in the same cycle SHALL complete the frame, no err.
REQ-023 WAIT_HI: further dclk rises ignored; synchronized drdyn high -> IDLE.
REQ-024 Latency: data/valid SHALL update SYNC_STAGES+1 clk edges after the edge at which the first sync stage first captures the final dclk high.
REQ-025 valid = 1 and ack = 1 SHALL clear valid and ovf on the next edge; ack with valid = 0 has no effect.
REQ-026 Frame completing with valid = 1 and ack = 0 SHALL overwrite data, keep valid = 1, set ovf.
REQ-027 Frame completing in the same cycle as ack SHALL load new data, keep valid = 1, leave ovf = 0.
REQ-028 Bit counter SHALL be ceil(log2(DATA_W+1)) bits and never wrap within a frame.

Reset
REQ-029 rstn = 0 SHALL immediately force FSM IDLE, data = 0, valid = 0, ovf = 0, err = 0, sel = 0, shift register, counter and synchronizers to 0 (drdyn chain to 1).
REQ-030 rstn deassert mid-frame SHALL discard that frame; reception restarts only at the next drdyn falling edge.

Verification
REQ-031 Reset, drdyn falls, 24 dclk pulses with dout = 0xA5C3F1 -> data = 0xA5C3F1, valid = 1, sel = 1, err = 0.
REQ-032 Two frames 0x000001 then 0xFFFFFF, no ack -> data = 0xFFFFFF, valid = 1, ovf = 1, sel = 0; then ack -> valid = 0, ovf = 0.
REQ-033 drdyn rises after 10 dclk pulses -> err pulses once, valid stays 0, sel stays 0; next full frame 0x123456 received correctly.
REQ-034 ack asserted in the cycle the 2nd frame completes -> data = 2nd word, valid = 1, ovf = 0.
REQ-035 rstn pulsed after 12 dclk pulses, then 12 more pulses with drdyn still low -> no valid, no err; next complete frame received correctly.
